// File: rtl/arc4_sched_pkg.sv
// rtl/arc4_sched_pkg.sv - shared state encoding, defaults and priority-encode helper for the ARC4 key-search scheduler
package arc4_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } sched_state_t;

  localparam int KEY_BITS_DEF = 24;
  localparam int MAX_CORES    = 16;

  function automatic logic [3:0] lowest_set(input logic [MAX_CORES-1:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = MAX_CORES - 1; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/arc4_crack_sched_if.sv
// rtl/arc4_crack_sched_if.sv - host handshake and crack-core dispatch bus of the key-search scheduler
interface arc4_crack_sched_if #(
  parameter int NUM_CORES = 2,
  parameter int KEY_BITS  = 24
) ();
  logic                          en;
  logic                          rdy;
  logic                          key_valid;
  logic [KEY_BITS-1:0]           key_out;
  logic [NUM_CORES-1:0]          core_start;
  logic [NUM_CORES*KEY_BITS-1:0] core_key;
  logic [NUM_CORES-1:0]          core_abort;
  logic [NUM_CORES-1:0]          core_done;
  logic [NUM_CORES-1:0]          core_match;

  modport master (
    input  en, core_done, core_match,
    output rdy, key_valid, key_out, core_start, core_key, core_abort
  );

  modport slave (
    output en, core_done, core_match,
    input  rdy, key_valid, key_out, core_start, core_key, core_abort
  );
endinterface

// File: rtl/arc4_sched_prio_enc.sv
// rtl/arc4_sched_prio_enc.sv - N-wide lowest-index priority encoder with any-valid flag
module arc4_sched_prio_enc
  import arc4_sched_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  logic [MAX_CORES-1:0] padded;

  always_comb begin
    padded        = '0;
    padded[N-1:0] = req;
  end

  assign idx = IDX_W'(lowest_set(padded));
  assign any = |req;
endmodule

// File: rtl/arc4_crack_sched.sv
// rtl/arc4_crack_sched.sv - NUM_CORES-wide ARC4 brute-force key dispatcher; ARC4_SCHED_PERF_EN adds perf counters
module arc4_crack_sched
  import arc4_sched_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int KEY_BITS  = KEY_BITS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  arc4_crack_sched_if.master bus
`ifdef ARC4_SCHED_PERF_EN
  ,
  output logic [KEY_BITS:0]  perf_keys,
  output logic [31:0]        perf_cycles
`endif
);
  localparam int CID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  sched_state_t         state, state_nxt;
  logic [KEY_BITS:0]    next_key;
  logic [NUM_CORES-1:0] busy, done_v, match_v, disp_vec, start_r, abort_r;
  logic [KEY_BITS-1:0]  key_r [NUM_CORES];
  logic                 key_valid_r;
  logic [KEY_BITS-1:0]  key_out_r;
  logic [CID_W-1:0]     idle_idx, win_idx;
  logic                 any_idle, any_match;
  logic                 found, dispatch, exhausted;

  // done/match from cores we never dispatched are protocol noise
  assign done_v  = bus.core_done & busy;
  assign match_v = done_v & bus.core_match;

  arc4_sched_prio_enc #(.N(NUM_CORES), .IDX_W(CID_W)) u_idle_pick (
    .req (~busy),
    .idx (idle_idx),
    .any (any_idle)
  );

  arc4_sched_prio_enc #(.N(NUM_CORES), .IDX_W(CID_W)) u_match_pick (
    .req (match_v),
    .idx (win_idx),
    .any (any_match)
  );

  assign found     = (state == ST_RUN) && any_match;
  assign dispatch  = (state == ST_RUN) && !found && !next_key[KEY_BITS] && any_idle;
  assign exhausted = (state == ST_RUN) && next_key[KEY_BITS] && (busy == '0);

  always_comb begin
    disp_vec = '0;
    if (dispatch) disp_vec[idle_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.en) state_nxt = ST_RUN;
      ST_RUN:  if (found || exhausted) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_key    <= '0;
      busy        <= '0;
      start_r     <= '0;
      abort_r     <= '0;
      key_valid_r <= 1'b0;
      key_out_r   <= '0;
      for (int i = 0; i < NUM_CORES; i++) key_r[i] <= '0;
    end else begin
      start_r <= '0;
      abort_r <= '0;
      case (state)
        ST_IDLE: begin
          if (bus.en) begin
            key_valid_r <= 1'b0;
            key_out_r   <= '0;
            next_key    <= '0;
          end
        end
        ST_RUN: begin
          if (found) begin
            key_valid_r <= 1'b1;
            key_out_r   <= key_r[win_idx];
            abort_r     <= busy & ~done_v;
            busy        <= busy & ~done_v;
          end else begin
            busy    <= (busy & ~done_v) | disp_vec;
            start_r <= disp_vec;
            if (dispatch) begin
              key_r[idle_idx] <= next_key[KEY_BITS-1:0];
              next_key        <= next_key + (KEY_BITS + 1)'(1);
            end
          end
        end
        default: busy <= '0;
      endcase
    end
  end

  assign bus.rdy        = (state == ST_IDLE);
  assign bus.key_valid  = key_valid_r;
  assign bus.key_out    = key_out_r;
  assign bus.core_start = start_r;
  assign bus.core_abort = abort_r;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_key
    assign bus.core_key[g*KEY_BITS +: KEY_BITS] = key_r[g];
  end

`ifdef ARC4_SCHED_PERF_EN
  logic [KEY_BITS:0] done_cnt;

  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) done_cnt = done_cnt + (KEY_BITS + 1)'(done_v[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_keys   <= '0;
      perf_cycles <= '0;
    end else if ((state == ST_IDLE) && bus.en) begin
      perf_keys   <= '0;
      perf_cycles <= '0;
    end else if (state == ST_RUN) begin
      perf_keys <= perf_keys + done_cnt;
      if (perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_arc4_crack_sched.sv
// tb/tb_arc4_crack_sched.sv - scoreboard bench for arc4_crack_sched; ARC4_SCHED_PERF_EN also checks perf counters
module tb_arc4_crack_sched;
  localparam int NC = 4;
  localparam int KB = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  arc4_crack_sched_if #(.NUM_CORES(NC), .KEY_BITS(KB)) bus ();

`ifdef ARC4_SCHED_PERF_EN
  logic [KB:0]  perf_keys;
  logic [31:0]  perf_cycles;
`endif

  arc4_crack_sched #(.NUM_CORES(NC), .KEY_BITS(KB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ARC4_SCHED_PERF_EN
    ,
    .perf_keys   (perf_keys),
    .perf_cycles (perf_cycles)
`endif
  );

  int compared   = 0;
  int mismatched = 0;

  int          ms;
  logic [NC-1:0] mb, d_q, m_q, inj_d, inj_m;
  logic        en_q, en_req;
  int          mnext;
  logic [KB-1:0] mkey [NC];
  int          cnt [NC];
  bit          mtbl [256];
  int          ltbl [256];
  int          starts_total;
  int          start_log [$];
  int          exp_q [$];

  function automatic int lowest(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    ms = 0; mb = '0; mnext = 0; d_q = '0; m_q = '0; en_q = 1'b0; en_req = 1'b0;
    inj_d = '0; inj_m = '0;
    for (int i = 0; i < NC; i++) begin cnt[i] = 0; mkey[i] = '0; end
    bus.en = 1'b0; bus.core_done = '0; bus.core_match = '0;
  endtask

  task automatic tables_reset();
    for (int k = 0; k < 256; k++) begin mtbl[k] = 1'b0; ltbl[k] = 3; end
  endtask

  task automatic cycle();
    logic [NC-1:0] es, ea, dv, mv, d, m;
    int prev, i0, e;
    @(posedge clk); #1;
    es = '0; ea = '0; prev = ms;
    case (ms)
      0: if (en_q) begin ms = 1; mnext = 0; end
      1: begin
        dv = d_q & mb; mv = dv & m_q;
        if (mv != '0) begin
          ms = 2; ea = mb & ~dv; mb = mb & ~dv;
        end else begin
          if (mnext < 256 && mb != '1) begin
            i0 = lowest(~mb); es[i0] = 1'b1; mkey[i0] = KB'(mnext); mnext++;
          end else if (mnext >= 256 && mb == '0) begin
            ms = 2;
          end
          mb = (mb & ~dv) | es;
        end
      end
      default: begin ms = 0; mb = '0; end
    endcase
    compared++;
    if (bus.core_start !== es) begin mismatched++; $display("FAIL core_start: got %b expected %b t=%0t", bus.core_start, es, $time); end
    compared++;
    if (bus.core_abort !== ea) begin mismatched++; $display("FAIL core_abort: got %b expected %b t=%0t", bus.core_abort, ea, $time); end
    compared++;
    if (bus.rdy !== (ms == 0)) begin mismatched++; $display("FAIL rdy: got %b expected %b t=%0t", bus.rdy, (ms == 0), $time); end
    for (int i = 0; i < NC; i++) begin
      if (es[i]) begin
        compared++;
        if (bus.core_key[i*KB +: KB] !== mkey[i]) begin
          mismatched++; $display("FAIL core_key[%0d]: got %h expected %h", i, bus.core_key[i*KB +: KB], mkey[i]);
        end
        start_log.push_back(i * 256 + int'(mkey[i]));
        starts_total++;
      end
    end
    if (prev == 2) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++; $display("FAIL result_unexpected: got valid=%b key=%h expected none", bus.key_valid, bus.key_out);
      end else begin
        e = exp_q.pop_front();
        if (bus.key_valid !== e[8] || bus.key_out !== e[7:0]) begin
          mismatched++; $display("FAIL result: got valid=%b key=%h expected valid=%b key=%h", bus.key_valid, bus.key_out, e[8], e[7:0]);
        end
      end
    end
    for (int i = 0; i < NC; i++) if (ea[i] || prev == 2) cnt[i] = 0;
    d = inj_d; m = inj_m; inj_d = '0; inj_m = '0;
    for (int i = 0; i < NC; i++) begin
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin d[i] = 1'b1; m[i] = mtbl[mkey[i]]; end
      end
    end
    for (int i = 0; i < NC; i++) if (es[i]) cnt[i] = ltbl[mkey[i]];
    bus.core_done = d; bus.core_match = m; bus.en = en_req;
    d_q = d; m_q = m; en_q = en_req; en_req = 1'b0;
  endtask

  task automatic run_to_idle(input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      cycle();
      if (ms == 0) break;
    end
    compared++;
    if (n >= budget) begin mismatched++; $display("FAIL timeout: got busy after %0d cycles expected idle", budget); end
  endtask

  task automatic run_search(input int valid, input int key, input int budget);
    exp_q.push_back((valid << 8) | key);
    en_req = 1'b1;
    cycle();
    run_to_idle(budget);
  endtask

  task automatic test_reset();
    model_reset();
    #1 rst = 1'b1;
    #2;
    compared++;
    if (bus.rdy !== 1'b1 || bus.key_valid !== 1'b0 || bus.key_out !== '0) begin
      mismatched++; $display("FAIL reset_host: got rdy=%b valid=%b key=%h expected 1 0 00", bus.rdy, bus.key_valid, bus.key_out);
    end
    compared++;
    if (bus.core_start !== '0 || bus.core_abort !== '0 || bus.core_key !== '0) begin
      mismatched++; $display("FAIL reset_core: got start=%b abort=%b key=%h expected zeros", bus.core_start, bus.core_abort, bus.core_key);
    end
    @(posedge clk); #1 rst = 1'b0;
    cycle(); cycle();
  endtask

  task automatic test_ascending();
    int exp_log [5];
    exp_log = '{0, 257, 514, 771, 4};
    tables_reset(); mtbl[10] = 1'b1;
    start_log.delete();
    exp_q.push_back((1 << 8) | 10);
    en_req = 1'b1;
    cycle(); cycle();
    inj_d = 4'b1000; inj_m = 4'b1000;
    run_to_idle(200);
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (start_log.size() <= i) begin
        mismatched++; $display("FAIL dispatch_order[%0d]: got none expected %0d", i, exp_log[i]);
      end else if (start_log[i] !== exp_log[i]) begin
        mismatched++; $display("FAIL dispatch_order[%0d]: got core%0d key%0d expected core%0d key%0d", i, start_log[i] / 256, start_log[i] % 256, exp_log[i] / 256, exp_log[i] % 256);
      end
    end
  endtask

  task automatic test_exhaustion();
    tables_reset();
    starts_total = 0;
    run_search(0, 0, 1000);
    cycle(); cycle(); cycle();
    compared++;
    if (starts_total !== 256) begin mismatched++; $display("FAIL start_count: got %0d expected 256", starts_total); end
`ifdef ARC4_SCHED_PERF_EN
    compared++;
    if (perf_keys !== 9'd256) begin mismatched++; $display("FAIL perf_keys: got %0d expected 256", perf_keys); end
`endif
  endtask

  task automatic test_single_match();
    tables_reset(); mtbl[8'h5A] = 1'b1;
    run_search(1, 8'h5A, 1000);
  endtask

  task automatic test_simul_match();
    tables_reset(); mtbl[8'h11] = 1'b1; mtbl[8'h0F] = 1'b1; ltbl[8'h0F] = 6;
    run_search(1, 8'h11, 500);
  endtask

  task automatic test_restart();
    tables_reset(); mtbl[3] = 1'b1;
    start_log.delete();
    exp_q.push_back((1 << 8) | 3);
    en_req = 1'b1;
    cycle(); cycle();
    compared++;
    if (bus.key_valid !== 1'b0 || bus.key_out !== '0) begin
      mismatched++; $display("FAIL restart_clear: got valid=%b key=%h expected 0 00", bus.key_valid, bus.key_out);
    end
`ifdef ARC4_SCHED_PERF_EN
    compared++;
    if (perf_keys !== '0) begin mismatched++; $display("FAIL perf_keys_clear: got %0d expected 0", perf_keys); end
`endif
    en_req = 1'b1;
    run_to_idle(200);
    compared++;
    if (start_log.size() == 0 || start_log[0] !== 0) begin
      mismatched++; $display("FAIL restart_key0: got %0d entries first=%0d expected key 0 on core 0", start_log.size(), (start_log.size() == 0) ? -1 : start_log[0]);
    end
  endtask

  task automatic test_reset_mid();
    tables_reset();
    en_req = 1'b1;
    cycle(); cycle(); cycle(); cycle(); cycle();
    rst = 1'b1;
    #2;
    compared++;
    if (bus.rdy !== 1'b1 || bus.key_valid !== 1'b0 || bus.key_out !== '0 || bus.core_start !== '0) begin
      mismatched++; $display("FAIL reset_mid: got rdy=%b valid=%b key=%h start=%b expected 1 0 00 0000", bus.rdy, bus.key_valid, bus.key_out, bus.core_start);
    end
    compared++;
    if (bus.core_key !== '0) begin mismatched++; $display("FAIL reset_mid_key: got %h expected 0", bus.core_key); end
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    cycle(); cycle();
  endtask

  initial begin
    tables_reset();
    starts_total = 0;
    test_reset();
    test_ascending();
    test_exhaustion();
    test_single_match();
    test_simul_match();
    test_restart();
    test_reset_mid();
    compared++;
    if (exp_q.size() != 0) begin mismatched++; $display("FAIL results_pending: got %0d expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
